// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte-level blocks: bridge FSM state
// encoding, command byte layout and the default idle MISO byte.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_WBUS  = 3'd3,
    ST_RBUS  = 3'd4
  } state_t;

  // Bit of the command byte that selects write (1) or read (0).
  localparam int CMD_WRITE_BIT = 7;

  // Byte shifted out on MISO whenever no read data is loaded.
  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'h00;

endpackage

// File: rtl/spi_reg_bridge.sv
// SPI byte stream to register-bus bridge. The first byte of a frame is a
// command (write bit + address), followed by write data bytes or dummy
// bytes that clock out read data. The address auto-increments per data
// byte. Bus requests are held until bus_ready; a byte arriving while a
// request is outstanding is dropped and flagged as a sticky overrun.
module spi_reg_bridge
  import spi_pkg::*;
#(
  parameter int         ADDR_WIDTH = 7,
  parameter bit         AUTO_INC   = 1'b1,
  parameter logic [7:0] FILL_BYTE  = FILL_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [7:0]            tx_data,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  output logic                  bus_we,
  output logic                  bus_re,
  input  logic [7:0]            bus_rdata,
  input  logic                  bus_ready,
  output logic                  err_overrun
);

  // Registered state
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_wdata;
  logic                  r_we;
  logic                  r_re;
  logic [7:0]            r_tx;
  logic                  r_ovr;
  // Set once the frame has ended while a request is still outstanding;
  // the access then runs to completion and the FSM returns to IDLE.
  logic                  r_drain;

  // Next-state values
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [7:0]            w_wdata_next;
  logic                  w_we_next;
  logic                  w_re_next;
  logic [7:0]            w_tx_next;
  logic                  w_ovr_next;
  logic                  w_drain_next;

  // Helpers
  logic [ADDR_WIDTH-1:0] w_cmd_addr;
  logic [ADDR_WIDTH-1:0] w_addr_adv;
  logic                  w_byte;

  // Command address field is 7 bits; fit it to the bus address width.
  generate
    if (ADDR_WIDTH > 7) begin : g_addr_ext
      assign w_cmd_addr = {{(ADDR_WIDTH-7){1'b0}}, rx_data[6:0]};
    end else begin : g_addr_trunc
      assign w_cmd_addr = rx_data[ADDR_WIDTH-1:0];
    end
  endgenerate

  // Address wraps naturally at 2^ADDR_WIDTH.
  assign w_addr_adv = AUTO_INC ? (r_addr + ADDR_WIDTH'(1)) : r_addr;

  // Bytes outside a frame are never acted upon.
  assign w_byte = rx_valid & frame;

  // Next-state and datapath decode for the bridge FSM.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;
    w_we_next    = r_we;
    w_re_next    = r_re;
    w_tx_next    = r_tx;
    w_ovr_next   = r_ovr;
    w_drain_next = r_drain;

    unique case (r_state)
      ST_IDLE: begin
        w_tx_next    = FILL_BYTE;
        w_drain_next = 1'b0;
        if (frame) begin
          w_state_next = ST_CMD;
        end
      end

      ST_CMD: begin
        if (!frame) begin
          w_state_next = ST_IDLE;
          w_tx_next    = FILL_BYTE;
        end else if (w_byte) begin
          w_addr_next = w_cmd_addr;
          if (rx_data[CMD_WRITE_BIT]) begin
            w_state_next = ST_WDATA;
          end else begin
            w_re_next    = 1'b1;
            w_state_next = ST_RBUS;
          end
        end
      end

      ST_WDATA: begin
        if (!frame) begin
          w_state_next = ST_IDLE;
          w_tx_next    = FILL_BYTE;
        end else if (w_byte) begin
          w_wdata_next = rx_data;
          w_we_next    = 1'b1;
          w_state_next = ST_WBUS;
        end
      end

      ST_WBUS: begin
        if (!frame) begin
          w_drain_next = 1'b1;
        end
        if (bus_ready) begin
          // Completion first; a same-cycle byte is then a normal data byte.
          w_we_next   = 1'b0;
          w_addr_next = w_addr_adv;
          if (r_drain || !frame) begin
            w_state_next = ST_IDLE;
            w_tx_next    = FILL_BYTE;
            w_drain_next = 1'b0;
            if (w_byte) begin
              w_ovr_next = 1'b1;
            end
          end else if (w_byte) begin
            w_wdata_next = rx_data;
            w_we_next    = 1'b1;
            w_state_next = ST_WBUS;
          end else begin
            w_state_next = ST_WDATA;
          end
        end else if (w_byte) begin
          w_ovr_next = 1'b1;
        end
      end

      ST_RBUS: begin
        if (r_re) begin
          if (!frame) begin
            w_drain_next = 1'b1;
          end
          if (bus_ready) begin
            w_re_next = 1'b0;
            if (r_drain || !frame) begin
              // Frame already over: read data has nowhere to go.
              w_state_next = ST_IDLE;
              w_tx_next    = FILL_BYTE;
              w_drain_next = 1'b0;
              if (w_byte) begin
                w_ovr_next = 1'b1;
              end
            end else begin
              w_tx_next = bus_rdata;
              if (w_byte) begin
                w_addr_next = w_addr_adv;
                w_re_next   = 1'b1;
              end
            end
          end else if (w_byte) begin
            w_ovr_next = 1'b1;
          end
        end else begin
          if (!frame) begin
            w_state_next = ST_IDLE;
            w_tx_next    = FILL_BYTE;
          end else if (w_byte) begin
            // Dummy byte clocks out the loaded data; prefetch the next one.
            w_addr_next = w_addr_adv;
            w_re_next   = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_we_next    = 1'b0;
        w_re_next    = 1'b0;
        w_tx_next    = FILL_BYTE;
        w_drain_next = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= 8'h00;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_tx    <= FILL_BYTE;
      r_ovr   <= 1'b0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_wdata <= w_wdata_next;
      r_we    <= w_we_next;
      r_re    <= w_re_next;
      r_tx    <= w_tx_next;
      r_ovr   <= w_ovr_next;
      r_drain <= w_drain_next;
    end
  end

  assign tx_data     = r_tx;
  assign bus_addr    = r_addr;
  assign bus_wdata   = r_wdata;
  assign bus_we      = r_we;
  assign bus_re      = r_re;
  assign err_overrun = r_ovr;

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
Byte-level command decoder that sits directly downstream of spi_controller. It consumes the parallel bytes that spi_controller receives within a chip-select frame, decodes a command/address header, and drives a simple request/ready register-bus master. It also supplies the byte that spi_controller shifts back on MISO. This block turns the raw SPI byte stream into register reads and writes with address auto-increment.

Parameters:
ADDR_WIDTH, 7, register-bus address width; the command byte carries the address in bits [6:0], zero-extended or truncated to ADDR_WIDTH.
AUTO_INC, 1, when 1 the address increments after each data byte; when 0 it stays fixed.
FILL_BYTE, 8'h00, value on tx_data whenever no read data is loaded.

Ports:
clk  input  1  system clock; same clock as spi_controller
rst  input  1  synchronous, active-high reset
frame  input  1  high while SPI chip-select is asserted (transaction active)
rx_valid  input  1  single-cycle strobe: rx_data holds a complete received byte
rx_data  input  8  received byte
tx_data  output  8  byte spi_controller shifts out during the next byte slot
bus_addr  output  ADDR_WIDTH  register-bus address
bus_wdata  output  8  write data
bus_we  output  1  write request; held until bus_ready
bus_re  output  1  read request; held until bus_ready
bus_rdata  input  8  read data; valid in the cycle bus_ready is high with bus_re
bus_ready  input  1  completes the pending request
err_overrun  output  1  sticky: a byte arrived while a bus access was still pending

Behaviour:
- Reset (synchronous, active-high, one cycle): state=IDLE, tx_data=FILL_BYTE, bus_we=0, bus_re=0, bus_addr=0, bus_wdata=0, err_overrun=0.
- The FSM has five states: IDLE, CMD, WDATA, WBUS and RBUS.
- IDLE: on frame rising (frame=1 while in IDLE), go to CMD; tx_data=FILL_BYTE.
- CMD: the first rx_valid is the command byte.
  - Latch bus_addr from rx_data[6:0].
  - If rx_data[7]=1 (write), go to WDATA.
  - Otherwise (read), assert bus_re the next cycle and go to RBUS.
- WDATA: on rx_valid, register bus_wdata=rx_data, assert bus_we the next cycle and go to WBUS.
- WBUS: hold bus_we, bus_addr and bus_wdata stable until the cycle bus_ready=1.
  - That cycle, deassert bus_we the next cycle.
  - Advance the address if AUTO_INC.
  - Return to WDATA.
- RBUS: hold bus_re until bus_ready=1.
  - That cycle, load tx_data<=bus_rdata and deassert bus_re.
  - On the next rx_valid (a dummy byte from the host), advance the address if AUTO_INC, reassert bus_re (prefetch) and stay in RBUS.
- Latency: a command byte at cycle N gives bus_re or bus_we high at N+1. With bus_ready at cycle M, tx_data updates at M+1.
- The address wraps from 2^ADDR_WIDTH-1 to 0 with no flag.
- Overrun: if rx_valid arrives while bus_we or bus_re is asserted and not yet acknowledged:
  - set err_overrun and drop the byte;
  - no address advance and no second request.
  - err_overrun clears only on rst.
- rx_valid and bus_ready in the same cycle: the completion is processed first, then the byte is treated as normal.
- frame falls:
  - With no request pending: go to IDLE the next cycle and set tx_data=FILL_BYTE.
  - With a request pending: complete the bus access (never abandon it; bus_rdata is discarded), then go to IDLE.
- rx_valid while frame=0 or while in IDLE is ignored.
- A new frame rising while the previous access is still draining is held off until IDLE is reached. Bytes that arrive before then are dropped and counted as overrun.
- bus_we and bus_re are never high together.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding enum (IDLE, CMD, WDATA, WBUS, RBUS);
  - CMD_WRITE_BIT=7;
  - default FILL_BYTE constant.
- No sub-module. A single FSM plus an address counter is natural. spi_controller and this block share spi_pkg.

Test Plan:
- Write burst:
  - Stimulus: frame=1, bytes 8'h85, 8'hAA, 8'h55; bus_ready 2 cycles after each request.
  - Required: writes addr 5 data AA, then addr 6 data 55; err_overrun=0.
- Read burst:
  - Stimulus: command 8'h10, bus returns 8'h3C at addr 0x10 and 8'hC3 at addr 0x11, two dummy bytes.
  - Required: tx_data=3C after the first ready, C3 after the second; bus_addr sequence 10, 11, 12.
- Wrap-around:
  - Stimulus: command 8'hFF, two data bytes.
  - Required: writes at addr 7F then 00.
- Overrun:
  - Stimulus: command 8'h82, data 8'h11, bus_ready held low, second rx_valid 8'h22, then ready.
  - Required: exactly one write (addr 2, 11); 22 dropped; err_overrun=1 until rst.
- Frame drop mid-access:
  - Stimulus: read request pending, frame falls, bus_ready 3 cycles later.
  - Required: bus_re held until ready, then IDLE; tx_data=00.
- Reset mid-operation:
  - Stimulus: rst during WBUS.
  - Required: next cycle bus_we=0, state IDLE, err_overrun=0, tx_data=00.
